// File: rtl/raizing_prio_mixer.sv
// raizing_prio_mixer: N-layer priority mixer plus always-on-top text layer.
// Two CEN-gated stages: capture/opacity, then winner select and output regs.
// A per-layer enable mask is staged in a pending register and only applied
// during vblank on a dot advance.
// Optional build macro: RAIZING_COLMIX_SOLO_EN adds SOLO_ON/SOLO_SEL to
// restrict opacity to a single chosen source.
module raizing_prio_mixer #(
  parameter int LAYERS = 4,
  parameter int IDX_W  = 11,
  parameter int PRIO_W = 4,
  parameter logic [IDX_W-1:0] BLANK = '0,
  localparam int PIX_W = PRIO_W + IDX_W,
  localparam int LW    = $clog2(LAYERS + 2)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    PIXEL_CEN,
  input  logic [LAYERS*PIX_W-1:0] LAYER_PIXEL,
  input  logic [IDX_W-1:0]        TEXT_PIXEL,
  input  logic                    ACTIVE,
  input  logic                    VBLANK,
  input  logic                    CFG_WR,
  input  logic [LAYERS:0]         LAYER_EN_IN,
`ifdef RAIZING_COLMIX_SOLO_EN
  input  logic                    SOLO_ON,
  input  logic [$clog2(LAYERS+1)-1:0] SOLO_SEL,
`endif
  output logic                    CFG_BUSY,
  output logic [IDX_W-1:0]        FINAL_PIXEL,
  output logic [LW-1:0]           FINAL_LAYER,
  output logic                    FINAL_VALID
);

  // Unpacked per-layer fields from the flat bus ({prio, index} per layer).
  logic [IDX_W-1:0]  lay_idx  [LAYERS];
  logic [PRIO_W-1:0] lay_prio [LAYERS];

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_unpack
    assign lay_idx[gi]  = LAYER_PIXEL[gi*PIX_W +: IDX_W];
    assign lay_prio[gi] = LAYER_PIXEL[gi*PIX_W + IDX_W +: PRIO_W];
  end

  // Configuration state
  logic [LAYERS:0] mask_q, mask_d;
  logic [LAYERS:0] pending_q, pending_d;
  logic            busy_q, busy_d;

  // Stage 1 state
  logic [IDX_W-1:0]  s1_idx_q  [LAYERS];
  logic [IDX_W-1:0]  s1_idx_d  [LAYERS];
  logic [PRIO_W-1:0] s1_prio_q [LAYERS];
  logic [PRIO_W-1:0] s1_prio_d [LAYERS];
  logic [LAYERS:0]   s1_opq_q, s1_opq_d;   // bit LAYERS = text
  logic [IDX_W-1:0]  s1_text_q, s1_text_d;
  logic              s1_active_q, s1_active_d;

  // Stage 2 / output state
  logic [IDX_W-1:0] out_pix_q, out_pix_d;
  logic [LW-1:0]    out_lay_q, out_lay_d;
  logic             out_val_q, out_val_d;

  // Solo gating: which sources may be opaque this dot (all when solo is off).
  logic [LAYERS:0] solo_ok;

  // Solo source selection (all sources allowed unless solo is built in and on)
  always_comb begin
    solo_ok = '1;
`ifdef RAIZING_COLMIX_SOLO_EN
    if (SOLO_ON) begin
      for (int k = 0; k <= LAYERS; k++) begin
        solo_ok[k] = (int'(SOLO_SEL) == k);
      end
    end
`endif
  end

  // Pending/active mask update; a write coinciding with apply goes straight in
  always_comb begin
    pending_d = CFG_WR ? LAYER_EN_IN : pending_q;
    mask_d    = mask_q;
    busy_d    = busy_q;
    if (VBLANK && PIXEL_CEN) begin
      mask_d = pending_d;
      busy_d = 1'b0;
    end else if (CFG_WR) begin
      busy_d = 1'b1;
    end
  end

  // Stage 1: capture fields, opacity (index, mask, solo) and ACTIVE on CEN
  always_comb begin
    s1_idx_d    = s1_idx_q;
    s1_prio_d   = s1_prio_q;
    s1_opq_d    = s1_opq_q;
    s1_text_d   = s1_text_q;
    s1_active_d = s1_active_q;
    if (PIXEL_CEN) begin
      for (int k = 0; k < LAYERS; k++) begin
        s1_idx_d[k]  = lay_idx[k];
        s1_prio_d[k] = lay_prio[k];
        s1_opq_d[k]  = (lay_idx[k] != '0) && mask_q[k] && solo_ok[k];
      end
      s1_text_d        = TEXT_PIXEL;
      s1_opq_d[LAYERS] = (TEXT_PIXEL != '0) && mask_q[LAYERS] && solo_ok[LAYERS];
      s1_active_d      = ACTIVE;
    end
  end

  // Winner among opaque layers: ascending scan with >= so that the higher
  // layer number takes a priority tie.
  logic              win_found;
  logic [PRIO_W-1:0] win_prio;
  logic [IDX_W-1:0]  win_idx;
  logic [LW-1:0]     win_lay;

  // Priority reduction over the registered stage-1 values
  always_comb begin
    win_found = 1'b0;
    win_prio  = '0;
    win_idx   = BLANK;
    win_lay   = LW'(LAYERS + 1);
    for (int k = 0; k < LAYERS; k++) begin
      if (s1_opq_q[k] && (!win_found || s1_prio_q[k] >= win_prio)) begin
        win_found = 1'b1;
        win_prio  = s1_prio_q[k];
        win_idx   = s1_idx_q[k];
        win_lay   = LW'(k);
      end
    end
  end

  // Stage 2: text override, then layer winner, else blank; hold without CEN
  always_comb begin
    out_pix_d = out_pix_q;
    out_lay_d = out_lay_q;
    out_val_d = out_val_q;
    if (PIXEL_CEN) begin
      out_val_d = s1_active_q;
      if (!s1_active_q) begin
        out_pix_d = BLANK;
        out_lay_d = LW'(LAYERS + 1);
      end else if (s1_opq_q[LAYERS]) begin
        out_pix_d = s1_text_q;
        out_lay_d = LW'(LAYERS);
      end else if (win_found) begin
        out_pix_d = win_idx;
        out_lay_d = win_lay;
      end else begin
        out_pix_d = BLANK;
        out_lay_d = LW'(LAYERS + 1);
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mask_q      <= '1;
      pending_q   <= '1;
      busy_q      <= 1'b0;
      for (int k = 0; k < LAYERS; k++) begin
        s1_idx_q[k]  <= '0;
        s1_prio_q[k] <= '0;
      end
      s1_opq_q    <= '0;
      s1_text_q   <= '0;
      s1_active_q <= 1'b0;
      out_pix_q   <= BLANK;
      out_lay_q   <= LW'(LAYERS + 1);
      out_val_q   <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      s1_idx_q    <= s1_idx_d;
      s1_prio_q   <= s1_prio_d;
      s1_opq_q    <= s1_opq_d;
      s1_text_q   <= s1_text_d;
      s1_active_q <= s1_active_d;
      out_pix_q   <= out_pix_d;
      out_lay_q   <= out_lay_d;
      out_val_q   <= out_val_d;
    end
  end

  assign CFG_BUSY    = busy_q;
  assign FINAL_PIXEL = out_pix_q;
  assign FINAL_LAYER = out_lay_q;
  assign FINAL_VALID = out_val_q;

endmodule

// File: doc/raizing_prio_mixer.md
# raizing_prio_mixer

Parametrised pixel priority mixer: successor to the fixed four-layer-plus-text colour mixer. Takes N tile/sprite layers, each carrying a priority field and palette index, plus one always-on-top text layer, and emits one palette index per dot to the palette RAM lookup. Adds a 2-stage CEN-gated pipeline, a per-layer enable mask applied only in vblank, and a winning-layer tag. Sits between the layer renderers and the palette/DAC stage in every Raizing core.

## Interface
- LAYERS, 4: number of priority-arbitrated layers, 2..8; layer 0 has the lowest bus position.
- IDX_W, 11: palette index width per layer and for text.
- PRIO_W, 4: priority field width per layer.
- BLANK, 0: index output when no layer is opaque or the dot is inactive.
- CLK  in  1  pixel-domain clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- PIXEL_CEN  in  1  dot-advance enable; pipeline moves only when high.
- LAYER_PIXEL  in  LAYERS*(PRIO_W+IDX_W)  layer k at bits [k*(PRIO_W+IDX_W) +: PRIO_W+IDX_W], {prio, index}.
- TEXT_PIXEL  in  IDX_W  text index; nonzero = opaque.
- ACTIVE  in  1  dot is inside the visible area.
- VBLANK  in  1  vertical blanking.
- CFG_WR  in  1  one-cycle strobe loading LAYER_EN_IN into the pending register.
- LAYER_EN_IN  in  LAYERS+1  enable per layer; bit LAYERS = text.
- CFG_BUSY  out  1  pending config not yet applied.
- FINAL_PIXEL  out  IDX_W  mixed palette index.
- FINAL_LAYER  out  $clog2(LAYERS+2)  winner: 0..LAYERS-1 layer, LAYERS text, LAYERS+1 blank.
- FINAL_VALID  out  1  ACTIVE delayed to align with FINAL_PIXEL.

## Operation
- Opaque: layer index field != 0 AND layer enabled in the active mask. Priority field does not affect opacity.
- Arbitration: among opaque layers, the highest prio value wins; on a tie the higher layer number wins.
- Text, if opaque, overrides every layer regardless of priority.
- No opaque source, or ACTIVE=0 at capture: FINAL_PIXEL=BLANK, FINAL_LAYER=LAYERS+1.
- Stage 1 (on CEN): register index, prio, opacity, ACTIVE. Stage 2 (on CEN): select winner with a comparator tree over registered values, register outputs.
- Config: CFG_WR loads pending register, sets CFG_BUSY. A later CFG_WR before apply overwrites pending. Apply when VBLANK=1 and PIXEL_CEN=1: active mask <= pending, CFG_BUSY <= 0. CFG_WR in the same cycle as apply: the new value is applied and CFG_BUSY stays 0.
- Active mask used at stage-1 capture; mask change never splits a dot.

## Timing
- Latency: 2 PIXEL_CEN pulses from input to outputs; outputs hold between CENs.
- Async reset: FINAL_PIXEL=BLANK, FINAL_LAYER=LAYERS+1, FINAL_VALID=0, CFG_BUSY=0, active and pending masks all ones, stage-1 registers cleared (treated as blank).
- Reset mid-frame: outputs go to reset values immediately; first valid output 2 CENs after release.
- CFG_BUSY rises the cycle after CFG_WR; falls the cycle after apply.
- PIXEL_CEN held high every cycle is legal (full-rate operation).

## Configuration
- RAIZING_COLMIX_SOLO_EN defined: adds inputs SOLO_ON (1) and SOLO_SEL ($clog2(LAYERS+1)); when SOLO_ON=1, only source SOLO_SEL (LAYERS = text) can be opaque, others forced transparent at stage 1, ANDed with the active mask.
- Not defined: ports absent; behaviour identical to SOLO_ON=0.

## Test plan
- Reset: RESET_N low mid-line with busy config -> FINAL_PIXEL=0, FINAL_LAYER=5, FINAL_VALID=0, CFG_BUSY=0 without a clock edge.
- Tie: LAYERS=4, L0 {3,0x010}, L1 {3,0x020}, L2 {1,0x030}, L3 index 0, ACTIVE=1 -> after 2 CENs FINAL_PIXEL=0x020, FINAL_LAYER=1, FINAL_VALID=1.
- Text: all layers {15,0x7FF}, TEXT_PIXEL=0x005 -> FINAL_PIXEL=0x005, FINAL_LAYER=4.
- Config: CFG_WR LAYER_EN_IN=5'b11101 with VBLANK=0 -> CFG_BUSY=1, L1 still wins the tie case; VBLANK=1 with CEN -> CFG_BUSY=0, then tie case yields 0x010, FINAL_LAYER=0.
- Inactive/stall: ACTIVE=0 -> FINAL_PIXEL=0, FINAL_LAYER=5, FINAL_VALID=0 after 2 CENs; PIXEL_CEN low for 10 cycles -> outputs unchanged.
- Solo (macro on): SOLO_ON=1, SOLO_SEL=2 with tie-case inputs -> FINAL_PIXEL=0x030, FINAL_LAYER=2.
